// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin priority search for the memory port arbiter.
package mem_arb_pkg;

    localparam int MAX_REQ  = 8;
    localparam int REQ_ID_W = $clog2(MAX_REQ);

    // Requester IDs are sized for the largest supported NUM_REQ so one type serves all instances.
    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } grant_t;

    // First eligible requester at or after ptr, wrapping at num_req.
    function automatic grant_t rr_next(input logic [MAX_REQ-1:0] elig,
                                       input req_id_t            ptr,
                                       input int                 num_req);
        grant_t g;
        int     idx;
        g = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < num_req) begin
                idx = int'(ptr) + k;
                if (idx >= num_req) idx = idx - num_req;
                if (!g.found && elig[idx[REQ_ID_W-1:0]]) begin
                    g.found = 1'b1;
                    g.id    = idx[REQ_ID_W-1:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Synchronous FIFO of requester IDs for reads issued to the RAM but not yet returned.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  req_id_t push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    req_id_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one RAM read port and one write port among NUM_REQ requesters.
// Handshake: a request transfers in the cycle req_valid[i] && req_ready[i]; ready is combinational and one-hot or zero.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 6,
    parameter int DATA_SIZE_BYTES = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_SIZE_BYTES*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_SIZE_BYTES*8-1:0]    rsp_data,
    output logic                            ram_rd_en,
    output logic [ADDR_WIDTH-1:0]           ram_rd_addr,
    input  logic [DATA_SIZE_BYTES*8-1:0]    ram_rd_data,
    input  logic                            ram_rd_valid,
    output logic                            ram_wr_en,
    output logic [ADDR_WIDTH-1:0]           ram_wr_addr,
    output logic [DATA_SIZE_BYTES*8-1:0]    ram_wr_data,
    output logic                            err_unexpected
);

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_SIZE_BYTES * 8;

    req_id_t              rr_ptr_q, rr_ptr_d;
    logic                 err_q, err_d;
    logic [MAX_REQ-1:0]   elig;
    grant_t               gnt;
    logic                 gnt_we;
    logic [AW-1:0]        gnt_addr;
    logic [DW-1:0]        gnt_wdata;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    req_id_t              fifo_head;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (req_we[i] || !fifo_full);
        end
        gnt = rr_next(elig, rr_ptr_q, NUM_REQ);
        if (rst) gnt.found = 1'b0;

        gnt_we    = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt.id == req_id_t'(i)) begin
                gnt_we       = req_we[i];
                gnt_addr     = req_addr[i*AW +: AW];
                gnt_wdata    = req_wdata[i*DW +: DW];
                req_ready[i] = gnt.found;
            end
        end

        ram_wr_en   = gnt.found && gnt_we;
        ram_rd_en   = gnt.found && !gnt_we;
        ram_wr_addr = gnt_addr;
        ram_wr_data = gnt_wdata;
        ram_rd_addr = gnt_addr;
        fifo_push   = ram_rd_en;

        // Returns are matched to IDs strictly in issue order; a return with nothing in flight is dropped.
        fifo_pop  = ram_rd_valid && !fifo_empty && !rst;
        rsp_data  = ram_rd_data;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = fifo_pop && (fifo_head == req_id_t'(i));
        end

        rr_ptr_d = rr_ptr_q;
        if (gnt.found) begin
            rr_ptr_d = (int'(gnt.id) == NUM_REQ - 1) ? '0 : gnt.id + 1'b1;
        end
        err_d = err_q || (ram_rd_valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign err_unexpected = err_q;

    mem_arb_id_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk),
        .rst_i    (rst),
        .push_i   (fifo_push),
        .push_id_i(gnt.id),
        .pop_i    (fifo_pop),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .head_o   (fifo_head)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a RAM stub and a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int MO = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data, ram_rd_data, ram_wr_data;
    logic            ram_rd_en, ram_rd_valid, ram_wr_en, err_unexpected;
    logic [AW-1:0]   ram_rd_addr, ram_wr_addr;

    mem_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_SIZE_BYTES(4), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_rd_valid(ram_rd_valid),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .err_unexpected(err_unexpected)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bench state
    logic [DW-1:0] ram     [64];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] ret_q[$];
    logic [DW-1:0] exp_q[$];
    int            id_q[$];
    int            glog[$];
    int            ref_ptr;
    bit            ref_err;
    bit            act [N];
    bit            a_we [N];
    logic [AW-1:0] a_addr [N];
    logic [DW-1:0] a_wd [N];
    logic [N-1:0]  vmask, wmask;
    int            load, wr_pct;
    bit            hold, inject, rst_req;
    int            n_checks, n_fail, cyc;
    int            ph_rd, ph_wr, n_rsp1;
    bit            got0;
    logic [DW-1:0] last0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_and_check();
        logic [N-1:0]  e_ready, e_rsp;
        logic          e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_data;
        int            g;
        bit            full;
        e_ready = '0; e_rsp = '0; e_rd = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_wd = '0; e_data = '0; g = -1;
        full = (id_q.size() >= MO);
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ref_ptr + k) % N;
                if (g < 0 && req_valid[i] && (req_we[i] || !full)) g = i;
            end
            if (g >= 0) begin
                e_ready[g] = 1'b1;
                e_addr = req_addr[g*AW +: AW];
                e_wd   = req_wdata[g*DW +: DW];
                if (req_we[g]) e_wr = 1'b1;
                else           e_rd = 1'b1;
            end
            if (ram_rd_valid && id_q.size() > 0) begin
                e_rsp[id_q[0]] = 1'b1;
                e_data = exp_q[0];
            end
        end
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("ram_rd_en", 64'(ram_rd_en), 64'(e_rd));
        check("ram_wr_en", 64'(ram_wr_en), 64'(e_wr));
        if (e_rd) check("ram_rd_addr", 64'(ram_rd_addr), 64'(e_addr));
        if (e_wr) begin
            check("ram_wr_addr", 64'(ram_wr_addr), 64'(e_addr));
            check("ram_wr_data", 64'(ram_wr_data), 64'(e_wd));
        end
        check("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        if (e_rsp != '0) check("rsp_data", 64'(rsp_data), 64'(e_data));
        check("err_unexpected", 64'(err_unexpected), 64'(ref_err));

        // RAM stub and requester environment react to what the DUT actually did
        if (ram_rd_en) begin
            ret_q.push_back(ram[ram_rd_addr]);
            ph_rd++;
        end
        if (ram_wr_en) begin
            ram[ram_wr_addr] = ram_wr_data;
            ph_wr++;
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                act[i] = 1'b0;
                glog.push_back(i);
            end
            if (rst) act[i] = 1'b0;
        end
        if (rsp_valid[0]) begin
            got0  = 1'b1;
            last0 = rsp_data;
        end
        if (rsp_valid[1]) n_rsp1++;

        // reference model state update
        if (rst) begin
            ref_ptr = 0;
            ref_err = 1'b0;
            id_q.delete();
            exp_q.delete();
        end else begin
            if (ram_rd_valid) begin
                if (id_q.size() > 0) begin
                    void'(id_q.pop_front());
                    void'(exp_q.pop_front());
                end else begin
                    ref_err = 1'b1;
                end
            end
            if (g >= 0) begin
                if (req_we[g]) ref_mem[e_addr] = e_wd;
                else begin
                    id_q.push_back(g);
                    exp_q.push_back(ref_mem[e_addr]);
                end
                ref_ptr = (g + 1) % N;
            end
        end
        cyc++;
    endtask

    // driver: all inputs change at the falling edge, checks follow 1 time unit later
    task automatic cycle();
        @(negedge clk);
        rst = rst_req;
        for (int i = 0; i < N; i++) begin
            if (!act[i] && vmask[i] && $urandom_range(99) < load) begin
                act[i]    = 1'b1;
                a_we[i]   = wmask[i] ? 1'b1 : ($urandom_range(99) < wr_pct);
                a_addr[i] = AW'($urandom_range(63));
                a_wd[i]   = $urandom;
            end
            req_valid[i]           = act[i];
            req_we[i]              = a_we[i];
            req_addr[i*AW +: AW]   = a_addr[i];
            req_wdata[i*DW +: DW]  = a_wd[i];
        end
        ram_rd_valid = 1'b0;
        ram_rd_data  = $urandom;
        if (!hold && ret_q.size() > 0) begin
            ram_rd_valid = 1'b1;
            ram_rd_data  = ret_q.pop_front();
        end else if (inject && ret_q.size() == 0 && id_q.size() == 0) begin
            ram_rd_valid = 1'b1;
        end
        #1;
        model_and_check();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic drain();
        int busy;
        vmask = '0; hold = 1'b0; inject = 1'b0;
        for (int k = 0; k < 60; k++) begin
            busy = ret_q.size() + id_q.size() + int'(act[0]) + int'(act[1]) + int'(act[2]);
            if (busy == 0) break;
            cycle();
        end
        busy = ret_q.size() + id_q.size() + int'(act[0]) + int'(act[1]) + int'(act[2]);
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;
    endtask

    task automatic check_grants(input string tag, input int a, input int b);
        check({tag, "_len"}, 64'(glog.size() >= 8), 64'd1);
        for (int k = 0; k < 8 && k < glog.size(); k++) begin
            check(tag, 64'(glog[k]), 64'((k % 2 == 0) ? a : b));
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        ref_ptr = 0; ref_err = 1'b0;
        hold = 1'b0; inject = 1'b0; load = 0; wr_pct = 0;
        vmask = '0; wmask = '0; n_rsp1 = 0; got0 = 1'b0; last0 = '0;
        rst = 1'b1; rst_req = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        ram_rd_valid = 1'b0; ram_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wd[i] = '0;
        end
        for (int a = 0; a < 64; a++) begin
            ram[a]     = $urandom;
            ref_mem[a] = ram[a];
        end

        // reset with requests pending, then idle
        vmask = '1; load = 100; wr_pct = 50;
        run(3);
        rst_req = 1'b0;
        vmask = '0;
        run(10);
        check("idle_err", 64'(err_unexpected), 64'd0);

        // write then read back through requester 0
        act[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 6'h05; a_wd[0] = 32'hDEADBEEF;
        for (int k = 0; k < 10 && act[0]; k++) cycle();
        check("wr_accepted", 64'(act[0]), 64'd0);
        act[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 6'h05; got0 = 1'b0; n_rsp1 = 0;
        for (int k = 0; k < 10 && !got0; k++) cycle();
        check("rd_back_seen", 64'(got0), 64'd1);
        check("rd_back_data", 64'(last0), 64'hDEADBEEF);
        check("rsp1_never", 64'(n_rsp1), 64'd0);

        // two continuous readers alternate 0,1,0,1
        drain(); do_reset();
        glog.delete();
        vmask = 3'b011; wmask = '0; wr_pct = 0; load = 100;
        run(8);
        check_grants("alt01", 0, 1);

        // returns held: two reads in flight block a third read, writes still pass
        drain(); do_reset();
        vmask = 3'b111; wmask = 3'b100; wr_pct = 0; load = 100; hold = 1'b1;
        ph_rd = 0; ph_wr = 0;
        run(8);
        check("held_reads", 64'(ph_rd), 64'd2);
        check("held_writes", 64'(ph_wr), 64'd6);
        hold = 1'b0;
        run(6);

        // wrap past the last requester: 2,0,2,0
        drain(); do_reset();
        act[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 6'h11;
        for (int k = 0; k < 10 && act[1]; k++) cycle();
        glog.delete();
        vmask = 3'b101; wmask = '0; wr_pct = 0; load = 100;
        run(8);
        check_grants("wrap20", 2, 0);

        // random traffic with intermittently stalled returns
        drain(); do_reset();
        vmask = 3'b111; wmask = '0; wr_pct = 40; load = 60;
        for (int k = 0; k < 300; k++) begin
            hold = ($urandom_range(3) == 0);
            cycle();
        end

        // unexpected return with nothing in flight
        drain();
        inject = 1'b1;
        run(2);
        inject = 1'b0;
        check("err_set", 64'(err_unexpected), 64'd1);
        run(5);
        check("err_sticky", 64'(err_unexpected), 64'd1);
        do_reset();
        run(1);
        check("err_cleared", 64'(err_unexpected), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
